// File: rtl/ip_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ip_sequencer_if
// Brief    : Decode-side control inputs and fetch-side IP outputs of the
//            IP sequencer.
// Revision : 1.0
// ============================================================================
interface ip_sequencer_if #(
  parameter int AW        = 8,
  parameter int RAS_DEPTH = 8,
  parameter int NINT      = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic            op_valid;
  logic [2:0]      op_class;
  logic [AW-1:0]   op_target;
  logic [1:0]      br_cond;
  logic            fl_zf;
  logic            fl_cf;
  logic            stall;
  logic [NINT-1:0] int_req;
  logic [NINT-1:0] int_mask;
  logic            err_clr;
  logic [AW-1:0]   IP;
  logic [NINT-1:0] int_ack;
  logic            in_isr;
  logic [CW-1:0]   ras_count;
  logic            ras_overflow;
  logic            ras_underflow;

  modport master (
    output op_valid, op_class, op_target, br_cond, fl_zf, fl_cf, stall,
           int_req, int_mask, err_clr,
    input  IP, int_ack, in_isr, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  op_valid, op_class, op_target, br_cond, fl_zf, fl_cf, stall,
           int_req, int_mask, err_clr,
    output IP, int_ack, in_isr, ras_count, ras_overflow, ras_underflow
  );
endinterface
`default_nettype wire

// File: rtl/ip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ip_sequencer
// Brief    : Next-IP sequencer with internal return-address stack and
//            vectored, maskable, non-nesting interrupts.
// Revision : 1.0
// ============================================================================
module ip_sequencer #(
  parameter int AW        = 8,
  parameter int RAS_DEPTH = 8,
  parameter int NINT      = 4,
  parameter int VEC_BASE  = 'hF0
) (
  input  wire logic     CLK,
  input  wire logic     RESET,
  ip_sequencer_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [CW-1:0] c_ras_full = CW'(RAS_DEPTH);
  localparam logic [AW-1:0] c_vec_base = AW'(VEC_BASE);
  localparam logic [2:0]    c_cls_jmp  = 3'd1;
  localparam logic [2:0]    c_cls_br   = 3'd2;
  localparam logic [2:0]    c_cls_call = 3'd3;
  localparam logic [2:0]    c_cls_ret  = 3'd4;
  localparam logic [2:0]    c_cls_iret = 3'd5;

  logic [AW-1:0]   r_ip;
  logic [AW-1:0]   r_ras [RAS_DEPTH];
  logic [CW-1:0]   r_cnt;
  logic            r_isr;
  logic [NINT-1:0] r_ack;
  logic            r_ovf;
  logic            r_unf;

  logic [NINT-1:0] w_pending;
  logic [NINT-1:0] w_int_onehot;
  logic [AW-1:0]   w_int_ofs;
  logic            w_take_int;
  logic            w_ras_full;
  logic            w_ras_empty;
  logic [PW-1:0]   w_push_idx;
  logic [PW-1:0]   w_top_idx;
  logic [AW-1:0]   w_ras_top;
  logic [AW-1:0]   w_ip_inc;
  logic            w_br_taken;

  assign w_pending   = bus.int_req & bus.int_mask;
  assign w_ras_full  = (r_cnt == c_ras_full);
  assign w_ras_empty = (r_cnt == '0);
  assign w_push_idx  = PW'(r_cnt);
  assign w_top_idx   = PW'(r_cnt - CW'(1));
  assign w_ras_top   = r_ras[w_top_idx];
  assign w_ip_inc    = r_ip + AW'(1);
  // A full RAS leaves the request pending rather than losing the return IP.
  assign w_take_int  = (|w_pending) && !r_isr && !w_ras_full;

  // Lowest-numbered pending line wins: scan downwards so it is written last.
  always_comb begin
    w_int_onehot = '0;
    w_int_ofs    = '0;
    for (int i = NINT - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_int_onehot    = '0;
        w_int_onehot[i] = 1'b1;
        w_int_ofs       = AW'(i);
      end
    end
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (bus.br_cond)
      2'd0:    w_br_taken = bus.fl_zf;
      2'd1:    w_br_taken = !bus.fl_zf;
      2'd2:    w_br_taken = bus.fl_cf;
      default: w_br_taken = !bus.fl_cf;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ip  <= '0;
      r_cnt <= '0;
      r_isr <= 1'b0;
      r_ack <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ack <= '0;
      if (!bus.stall) begin
        // Clear first so an error raised below in the same cycle wins.
        if (bus.err_clr) begin
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
        end
        if (w_take_int) begin
          r_ras[w_push_idx] <= r_ip;
          r_cnt             <= r_cnt + CW'(1);
          r_ip              <= c_vec_base + w_int_ofs;
          r_isr             <= 1'b1;
          r_ack             <= w_int_onehot;
        end else if (bus.op_valid) begin
          case (bus.op_class)
            c_cls_jmp: r_ip <= bus.op_target;
            c_cls_br:  r_ip <= w_br_taken ? bus.op_target : w_ip_inc;
            c_cls_call: begin
              if (w_ras_full) begin
                r_ovf <= 1'b1;
              end else begin
                r_ras[w_push_idx] <= w_ip_inc;
                r_cnt             <= r_cnt + CW'(1);
              end
              r_ip <= bus.op_target;
            end
            c_cls_ret, c_cls_iret: begin
              if (w_ras_empty) begin
                r_ip  <= w_ip_inc;
                r_unf <= 1'b1;
              end else begin
                r_ip  <= w_ras_top;
                r_cnt <= r_cnt - CW'(1);
              end
              if (bus.op_class == c_cls_iret) begin
                r_isr <= 1'b0;
              end
            end
            default: r_ip <= w_ip_inc;
          endcase
        end
      end
    end
  end

  assign bus.IP            = r_ip;
  assign bus.int_ack       = r_ack;
  assign bus.in_isr        = r_isr;
  assign bus.ras_count     = r_cnt;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_ip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_sequencer
// Brief    : Directed and random checks of ip_sequencer against a queue model.
// Revision : 1.0
// ============================================================================
module tb_ip_sequencer;
  localparam int AW  = 8;
  localparam int RD  = 4;
  localparam int NI  = 4;
  localparam int VB  = 'hF0;
  localparam int MOD = 1 << AW;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ip_sequencer_if #(.AW(AW), .RAS_DEPTH(RD), .NINT(NI)) bus ();

  ip_sequencer #(.AW(AW), .RAS_DEPTH(RD), .NINT(NI), .VEC_BASE(VB)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  int m_ip;
  int m_ras[$];
  int m_isr;
  int m_ack;
  int m_ovf;
  int m_unf;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic bit cond_holds(input int c, input bit zf, input bit cf);
    return (c == 0 && zf) || (c == 1 && !zf) || (c == 2 && cf) || (c == 3 && !cf);
  endfunction

  // Reference behaviour, applied once per rising edge to the sampled inputs.
  task automatic model_step();
    int pend;
    int k;
    int cls;
    if (RESET) begin
      m_ip = 0; m_ras.delete(); m_isr = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
    end else if (bus.stall) begin
      m_ack = 0;
    end else begin
      m_ack = 0;
      if (bus.err_clr) begin
        m_ovf = 0; m_unf = 0;
      end
      pend = int'(bus.int_req & bus.int_mask);
      cls  = int'(bus.op_class);
      if (pend != 0 && m_isr == 0 && m_ras.size() < RD) begin
        k = 0;
        while (((pend >> k) & 1) == 0) k++;
        m_ras.push_back(m_ip);
        m_ip  = (VB + k) % MOD;
        m_isr = 1;
        m_ack = 1 << k;
      end else if (bus.op_valid) begin
        if (cls == 1) begin
          m_ip = int'(bus.op_target);
        end else if (cls == 2) begin
          m_ip = cond_holds(int'(bus.br_cond), bus.fl_zf, bus.fl_cf) ?
                 int'(bus.op_target) : (m_ip + 1) % MOD;
        end else if (cls == 3) begin
          if (m_ras.size() < RD) m_ras.push_back((m_ip + 1) % MOD);
          else m_ovf = 1;
          m_ip = int'(bus.op_target);
        end else if (cls == 4 || cls == 5) begin
          if (m_ras.size() > 0) m_ip = m_ras.pop_back();
          else begin
            m_ip = (m_ip + 1) % MOD; m_unf = 1;
          end
          if (cls == 5) m_isr = 0;
        end else begin
          m_ip = (m_ip + 1) % MOD;
        end
      end
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ip",            int'(bus.IP),            m_ip);
      check("int_ack",       int'(bus.int_ack),       m_ack);
      check("in_isr",        int'(bus.in_isr),        m_isr);
      check("ras_count",     int'(bus.ras_count),     m_ras.size());
      check("ras_overflow",  int'(bus.ras_overflow),  m_ovf);
      check("ras_underflow", int'(bus.ras_underflow), m_unf);
    end
  end

  task automatic step();
    @(posedge CLK);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic op(input int cls, input int tgt);
    bus.op_valid  = 1'b1;
    bus.op_class  = 3'(cls);
    bus.op_target = 8'(tgt);
    step();
  endtask

  initial begin
    RESET = 1'b1;
    bus.op_valid = 1'b0; bus.op_class = '0; bus.op_target = '0;
    bus.br_cond = '0; bus.fl_zf = 1'b0; bus.fl_cf = 1'b0; bus.stall = 1'b0;
    bus.int_req = '0; bus.int_mask = '1; bus.err_clr = 1'b0;
    step(); step();
    check("rst_ip",   int'(bus.IP), 0);
    check("rst_cnt",  int'(bus.ras_count), 0);
    check("rst_isr",  int'(bus.in_isr), 0);
    check("rst_ack",  int'(bus.int_ack), 0);
    check("rst_flag", int'(bus.ras_overflow | bus.ras_underflow), 0);
    RESET = 1'b0;

    repeat (3) op(0, 0);
    check("seq_ip", int'(bus.IP), 3);
    op(1, 'hFF); check("jmp_ip", int'(bus.IP), 'hFF);
    op(0, 0);    check("wrap_ip", int'(bus.IP), 0);

    op(1, 5); bus.br_cond = 2'd0; bus.fl_zf = 1'b1; op(2, 'h20);
    check("br_zf_taken", int'(bus.IP), 'h20);
    op(1, 5); bus.br_cond = 2'd2; bus.fl_cf = 1'b0; op(2, 'h20);
    check("br_cf_not", int'(bus.IP), 6);
    bus.fl_zf = 1'b0;

    op(1, 3); op(3, 'h40);
    check("call_ip", int'(bus.IP), 'h40); check("call_cnt", int'(bus.ras_count), 1);
    op(4, 0);
    check("ret_ip", int'(bus.IP), 4); check("ret_cnt", int'(bus.ras_count), 0);
    repeat (5) op(3, 'h10);
    check("ovf_flag", int'(bus.ras_overflow), 1); check("ovf_cnt", int'(bus.ras_count), 4);
    repeat (4) op(4, 0);
    check("ret4_ip", int'(bus.IP), 5);
    op(4, 0);
    check("unf_flag", int'(bus.ras_underflow), 1); check("unf_ip", int'(bus.IP), 6);
    bus.err_clr = 1'b1; op(0, 0); bus.err_clr = 1'b0;
    check("clr_flags", int'(bus.ras_overflow | bus.ras_underflow), 0);

    bus.int_mask = 4'b1111; bus.int_req = 4'b0110; op(0, 0);
    check("int_ip", int'(bus.IP), 'hF1); check("int_ack", int'(bus.int_ack), 2);
    check("int_isr", int'(bus.in_isr), 1); check("int_cnt", int'(bus.ras_count), 1);
    bus.int_req = 4'b0001; op(0, 0);
    check("nest_ip", int'(bus.IP), 'hF2); check("ack_once", int'(bus.int_ack), 0);
    op(5, 0);
    check("iret_ip", int'(bus.IP), 7); check("iret_isr", int'(bus.in_isr), 0);
    op(0, 0);
    check("int0_ip", int'(bus.IP), 'hF0);
    bus.int_req = '0; op(5, 0);

    bus.int_req = 4'b1000; bus.stall = 1'b1; op(3, 'h55);
    check("stall_ip", int'(bus.IP), 7); check("stall_ack", int'(bus.int_ack), 0);
    check("stall_cnt", int'(bus.ras_count), 0);
    bus.stall = 1'b0; op(3, 'h55);
    check("unstall_ip", int'(bus.IP), 'hF3); check("unstall_ack", int'(bus.int_ack), 8);
    bus.int_req = '0; op(5, 0);

    bus.int_mask = '0; bus.int_req = '1; repeat (3) op(0, 0);
    check("mask_isr", int'(bus.in_isr), 0); check("mask_ip", int'(bus.IP), 'h0A);
    bus.int_req = '0; bus.int_mask = '1;

    op(3, 'h30); bus.int_req = 4'b0010; op(0, 0);
    check("pre_rst_cnt", int'(bus.ras_count), 2);
    bus.int_req = '0; RESET = 1'b1; step(); RESET = 1'b0;
    check("midisr_ip", int'(bus.IP), 0); check("midisr_isr", int'(bus.in_isr), 0);
    check("midisr_cnt", int'(bus.ras_count), 0);

    repeat (4000) begin
      RESET         = ($urandom_range(0, 99) == 0);
      bus.stall     = ($urandom_range(0, 99) < 15);
      bus.op_valid  = ($urandom_range(0, 99) < 85);
      bus.op_class  = 3'($urandom_range(0, 7));
      bus.op_target = 8'($urandom);
      bus.br_cond   = 2'($urandom);
      bus.fl_zf     = 1'($urandom);
      bus.fl_cf     = 1'($urandom);
      bus.int_req   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      bus.int_mask  = 4'($urandom);
      bus.err_clr   = ($urandom_range(0, 99) < 5);
      step();
    end

    @(negedge CLK); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
